// File: rtl/traffic_mon_pkg.sv
// Shared types and decode helpers for the traffic-light monitor.
// Phase encoding, legal successor function and lamp-to-phase decode.
package traffic_mon_pkg;

    typedef enum logic [1:0] {
        PH_NONE  = 2'd0,
        PH_RED   = 2'd1,
        PH_GREEN = 2'd2,
        PH_AMBER = 2'd3
    } phase_t;

    function automatic phase_t next_phase(input phase_t p);
        case (p)
            PH_RED:   next_phase = PH_GREEN;
            PH_GREEN: next_phase = PH_AMBER;
            PH_AMBER: next_phase = PH_RED;
            default:  next_phase = PH_NONE;
        endcase
    endfunction

    // Only a single lit lamp maps to a colour; dark or overlap maps to NONE.
    function automatic phase_t lamps_to_phase(input logic r, input logic a, input logic g);
        case ({r, a, g})
            3'b100:  lamps_to_phase = PH_RED;
            3'b010:  lamps_to_phase = PH_AMBER;
            3'b001:  lamps_to_phase = PH_GREEN;
            default: lamps_to_phase = PH_NONE;
        endcase
    endfunction

    function automatic logic multi_lamp(input logic r, input logic a, input logic g);
        multi_lamp = (r & a) | (r & g) | (a & g);
    endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Lamp inputs and monitor result bundle; master drives lamps, slave is the monitor.
interface traffic_light_monitor_if #(
    parameter int unsigned CNT_W = 32'd32
);
    import traffic_mon_pkg::*;

    logic             red;
    logic             amber;
    logic             green;
    phase_t           phase;
    logic             phase_done;
    phase_t           done_phase;
    logic [CNT_W-1:0] measured_tics;
    logic             time_err;
    logic             seq_err;
    logic             overlap_err;
    logic             dark_err;

    modport master (
        output red, amber, green,
        input  phase, phase_done, done_phase, measured_tics,
        input  time_err, seq_err, overlap_err, dark_err
    );

    modport slave (
        input  red, amber, green,
        output phase, phase_done, done_phase, measured_tics,
        output time_err, seq_err, overlap_err, dark_err
    );

endinterface

// File: rtl/sat_tic_counter.sv
// Saturating tic counter with clear / load-one / increment controls.
module sat_tic_counter #(
    parameter int unsigned CNT_W = 32'd32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             load1,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Priority: clear, then load1, then increment (holding at all-ones).
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= {CNT_W{1'b0}};
        end else if (clear) begin
            count <= {CNT_W{1'b0}};
        end else if (load1) begin
            count <= CNT_W'(1);
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker of red->green->amber->red sequencing and phase durations.
// Optional dark watchdog enabled by defining TRAFFIC_MON_WATCHDOG_EN.
module traffic_light_monitor
    import traffic_mon_pkg::*;
#(
    parameter int unsigned RED_TICS   = 32'd350,
    parameter int unsigned GREEN_TICS = 32'd200,
    parameter int unsigned AMBER_TICS = 32'd30,
    parameter int unsigned TOL        = 32'd0,
    parameter int unsigned CNT_W      = 32'd32,
    parameter int unsigned DARK_MAX   = 32'd2
) (
    input  logic                   clock,
    input  logic                   reset,
    traffic_light_monitor_if.slave mon
);

    localparam int unsigned WW = CNT_W + 32'd1;

    phase_t           state_r, state_s;
    phase_t           exp_r, exp_s;
    phase_t           lit_s;
    phase_t           done_phase_r;
    logic             multi_s, done_s, seq_bad_s, time_bad_s, dark_hit_s;
    logic             cnt_clear_s, cnt_load1_s, cnt_inc_s;
    logic [CNT_W-1:0] cnt_s, measured_r;
    logic [WW-1:0]    meas_w_s, exp_w_s, diff_s;
    logic             phase_done_r, time_err_r, seq_err_r, overlap_err_r, dark_err_r;

    assign lit_s     = lamps_to_phase(mon.red, mon.amber, mon.green);
    assign multi_s   = multi_lamp(mon.red, mon.amber, mon.green);
    assign done_s    = (state_r != PH_NONE) && !multi_s && (lit_s != state_r);
    // exp_r == NONE means unsynchronised: the next entered colour is not checked.
    assign seq_bad_s = !multi_s && (lit_s != PH_NONE) && (lit_s != state_r) &&
                       (exp_r != PH_NONE) && (lit_s != exp_r);

    sat_tic_counter #(.CNT_W(CNT_W)) u_phase_cnt (
        .clock (clock),
        .reset (reset),
        .clear (cnt_clear_s),
        .load1 (cnt_load1_s),
        .inc   (cnt_inc_s),
        .count (cnt_s)
    );

`ifdef TRAFFIC_MON_WATCHDOG_EN
    logic [CNT_W-1:0] dark_cnt_s;
    logic             dark_sync_s;

    assign dark_sync_s = !multi_s && (lit_s == PH_NONE) && (exp_r != PH_NONE);
    assign dark_hit_s  = dark_sync_s && (dark_cnt_s >= CNT_W'(DARK_MAX));

    sat_tic_counter #(.CNT_W(CNT_W)) u_dark_cnt (
        .clock (clock),
        .reset (reset),
        .clear (!dark_sync_s || dark_hit_s),
        .load1 (1'b0),
        .inc   (1'b1),
        .count (dark_cnt_s)
    );
`else
    assign dark_hit_s = 1'b0;
`endif

    // Next phase, expected successor and phase-counter control.
    always_comb begin
        state_s     = state_r;
        exp_s       = exp_r;
        cnt_clear_s = 1'b0;
        cnt_load1_s = 1'b0;
        cnt_inc_s   = 1'b0;
        if (multi_s) begin
            state_s     = PH_NONE;
            exp_s       = PH_NONE;
            cnt_clear_s = 1'b1;
        end else if (lit_s == PH_NONE) begin
            state_s     = PH_NONE;
            cnt_clear_s = 1'b1;
            exp_s       = dark_hit_s ? PH_NONE : exp_r;
        end else if (lit_s == state_r) begin
            cnt_inc_s   = 1'b1;
        end else begin
            state_s     = lit_s;
            cnt_load1_s = 1'b1;
            exp_s       = seq_bad_s ? PH_NONE : next_phase(lit_s);
        end
    end

    // Duration check at one extra bit so the difference never wraps.
    always_comb begin
        case (state_r)
            PH_RED:   exp_w_s = WW'(RED_TICS);
            PH_GREEN: exp_w_s = WW'(GREEN_TICS);
            PH_AMBER: exp_w_s = WW'(AMBER_TICS);
            default:  exp_w_s = {WW{1'b0}};
        endcase
        meas_w_s = {1'b0, cnt_s};
        if (meas_w_s >= exp_w_s) begin
            diff_s = meas_w_s - exp_w_s;
        end else begin
            diff_s = exp_w_s - meas_w_s;
        end
        time_bad_s = (diff_s > WW'(TOL));
    end

    // State and registered result outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= PH_NONE;
            exp_r         <= PH_NONE;
            phase_done_r  <= 1'b0;
            done_phase_r  <= PH_NONE;
            measured_r    <= {CNT_W{1'b0}};
            time_err_r    <= 1'b0;
            seq_err_r     <= 1'b0;
            overlap_err_r <= 1'b0;
            dark_err_r    <= 1'b0;
        end else begin
            state_r       <= state_s;
            exp_r         <= exp_s;
            phase_done_r  <= done_s;
            done_phase_r  <= done_s ? state_r : done_phase_r;
            measured_r    <= done_s ? cnt_s : measured_r;
            time_err_r    <= done_s && time_bad_s;
            seq_err_r     <= seq_bad_s;
            overlap_err_r <= multi_s;
            dark_err_r    <= dark_hit_s;
        end
    end

    assign mon.phase         = state_r;
    assign mon.phase_done    = phase_done_r;
    assign mon.done_phase    = done_phase_r;
    assign mon.measured_tics = measured_r;
    assign mon.time_err      = time_err_r;
    assign mon.seq_err       = seq_err_r;
    assign mon.overlap_err   = overlap_err_r;
    assign mon.dark_err      = dark_err_r;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed, table-driven bench for traffic_light_monitor (TOL=0 and TOL=2 instances).
module tb_traffic_light_monitor;
    import traffic_mon_pkg::*;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    traffic_light_monitor_if #(.CNT_W(32'd32)) b0 ();
    traffic_light_monitor_if #(.CNT_W(32'd32)) b2 ();

    traffic_light_monitor #(.TOL(32'd0)) dut0 (.clock(clock), .reset(reset), .mon(b0.slave));
    traffic_light_monitor #(.TOL(32'd2)) dut2 (.clock(clock), .reset(reset), .mon(b2.slave));

    typedef struct {
        logic [2:0] lamps;
        int         tics;
        logic       done;
        phase_t     dph;
        int         meas;
        logic       terr0;
        logic       terr2;
        logic       seq;
        logic       ovl;
        phase_t     ph;
    } vec_t;

    vec_t vt[16];

    function automatic vec_t mk(input logic [2:0] l, input int t, input logic d, input phase_t dp,
                                input int m, input logic t0, input logic t2, input logic s,
                                input logic o, input phase_t p);
        vec_t v;
        v.lamps = l; v.tics = t; v.done = d; v.dph = dp; v.meas = m;
        v.terr0 = t0; v.terr2 = t2; v.seq = s; v.ovl = o; v.ph = p;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_lamps(input logic [2:0] l);
        b0.red = l[2]; b0.amber = l[1]; b0.green = l[0];
        b2.red = l[2]; b2.amber = l[1]; b2.green = l[0];
    endtask

    function automatic int pulses();
        return int'(b0.phase_done) + int'(b0.seq_err) + int'(b0.overlap_err) + int'(b0.time_err) +
               int'(b0.dark_err) + int'(b2.phase_done) + int'(b2.time_err) + int'(b2.dark_err);
    endfunction

    localparam logic [2:0] R = 3'b100, A = 3'b010, G = 3'b001, D = 3'b000;
    logic wd;

    initial begin
`ifdef TRAFFIC_MON_WATCHDOG_EN
        wd = 1'b1;
`else
        wd = 1'b0;
`endif
        vt[0]  = mk(R, 350, 1'b0, PH_NONE,    0, 1'b0, 1'b0, 1'b0, 1'b0, PH_RED);
        vt[1]  = mk(G, 200, 1'b1, PH_RED,   350, 1'b0, 1'b0, 1'b0, 1'b0, PH_GREEN);
        vt[2]  = mk(A,  30, 1'b1, PH_GREEN, 200, 1'b0, 1'b0, 1'b0, 1'b0, PH_AMBER);
        vt[3]  = mk(R, 352, 1'b1, PH_AMBER,  30, 1'b0, 1'b0, 1'b0, 1'b0, PH_RED);
        vt[4]  = mk(G, 200, 1'b1, PH_RED,   352, 1'b1, 1'b0, 1'b0, 1'b0, PH_GREEN);
        vt[5]  = mk(A,  30, 1'b1, PH_GREEN, 200, 1'b0, 1'b0, 1'b0, 1'b0, PH_AMBER);
        vt[6]  = mk(R, 350, 1'b1, PH_AMBER,  30, 1'b0, 1'b0, 1'b0, 1'b0, PH_RED);
        vt[7]  = mk(A,  30, 1'b1, PH_RED,   350, 1'b0, 1'b0, 1'b1, 1'b0, PH_AMBER);
        vt[8]  = mk(G, 200, 1'b1, PH_AMBER,  30, 1'b0, 1'b0, 1'b0, 1'b0, PH_GREEN);
        vt[9]  = mk(3'b101, 1, 1'b0, PH_NONE, 0, 1'b0, 1'b0, 1'b0, 1'b1, PH_NONE);
        vt[10] = mk(A,  30, 1'b0, PH_NONE,    0, 1'b0, 1'b0, 1'b0, 1'b0, PH_AMBER);
        vt[11] = mk(D,   2, 1'b1, PH_AMBER,  30, 1'b0, 1'b0, 1'b0, 1'b0, PH_NONE);
        vt[12] = mk(R,  10, 1'b0, PH_NONE,    0, 1'b0, 1'b0, 1'b0, 1'b0, PH_RED);
        vt[13] = mk(D,   1, 1'b1, PH_RED,    10, 1'b1, 1'b1, 1'b0, 1'b0, PH_NONE);
        vt[14] = mk(A,   3, 1'b0, PH_NONE,    0, 1'b0, 1'b0, 1'b1, 1'b0, PH_AMBER);
        vt[15] = mk(G, 100, 1'b1, PH_AMBER,   3, 1'b1, 1'b1, 1'b0, 1'b0, PH_GREEN);

        reset = 1'b1;
        set_lamps(D);
        repeat (3) tick();
        chk("rst_phase", 64'(b0.phase), 64'(PH_NONE));
        chk("rst_done", 64'(b0.phase_done), 64'd0);
        chk("rst_dphase", 64'(b0.done_phase), 64'(PH_NONE));
        chk("rst_meas", 64'(b0.measured_tics), 64'd0);
        chk("rst_errs", 64'({b0.time_err, b0.seq_err, b0.overlap_err, b0.dark_err}), 64'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 16; i++) begin
            int stray;
            set_lamps(vt[i].lamps);
            tick();
            chk($sformatf("v%0d_phase", i), 64'(b0.phase), 64'(vt[i].ph));
            chk($sformatf("v%0d_done", i), 64'(b0.phase_done), 64'(vt[i].done));
            chk($sformatf("v%0d_done2", i), 64'(b2.phase_done), 64'(vt[i].done));
            chk($sformatf("v%0d_seq", i), 64'(b0.seq_err), 64'(vt[i].seq));
            chk($sformatf("v%0d_ovl", i), 64'(b0.overlap_err), 64'(vt[i].ovl));
            chk($sformatf("v%0d_terr0", i), 64'(b0.time_err), 64'(vt[i].terr0));
            chk($sformatf("v%0d_terr2", i), 64'(b2.time_err), 64'(vt[i].terr2));
            if (vt[i].done) begin
                chk($sformatf("v%0d_dphase", i), 64'(b0.done_phase), 64'(vt[i].dph));
                chk($sformatf("v%0d_meas", i), 64'(b0.measured_tics), 64'(vt[i].meas));
                chk($sformatf("v%0d_meas2", i), 64'(b2.measured_tics), 64'(vt[i].meas));
            end
            stray = 0;
            for (int t = 1; t < vt[i].tics; t++) begin
                tick();
                stray += pulses() + ((b0.phase != vt[i].ph) ? 1 : 0);
            end
            chk($sformatf("v%0d_stray", i), 64'(stray), 64'd0);
        end

        // Reset 100 tics into green: outputs cleared, green count discarded.
        reset = 1'b1;
        tick();
        chk("mid_rst_phase", 64'(b0.phase), 64'(PH_NONE));
        chk("mid_rst_meas", 64'(b0.measured_tics), 64'd0);
        chk("mid_rst_dphase", 64'(b0.done_phase), 64'(PH_NONE));
        chk("mid_rst_done", 64'(pulses()), 64'd0);
        reset = 1'b0;
        tick();
        chk("post_rst_phase", 64'(b0.phase), 64'(PH_GREEN));
        chk("post_rst_pulses", 64'(pulses() + int'(b0.seq_err)), 64'd0);
        repeat (4) tick();
        set_lamps(D);
        tick();
        chk("post_rst_done", 64'(b0.phase_done), 64'd1);
        chk("post_rst_meas", 64'(b0.measured_tics), 64'd5);

        // Amber then three dark tics: watchdog fires once on the third.
        set_lamps(A);
        tick();
        chk("wd_amber_seq", 64'(b0.seq_err), 64'd0);
        repeat (29) tick();
        set_lamps(D);
        tick();
        chk("wd_done", 64'(b0.phase_done), 64'd1);
        chk("wd_meas", 64'(b0.measured_tics), 64'd30);
        chk("wd_dark1", 64'(b0.dark_err), 64'd0);
        tick();
        chk("wd_dark2", 64'(b0.dark_err), 64'd0);
        tick();
        chk("wd_dark3", 64'(b0.dark_err), 64'(wd));
        chk("wd_dark3_b2", 64'(b2.dark_err), 64'(wd));
        tick();
        chk("wd_dark4", 64'(b0.dark_err), 64'd0);
        set_lamps(G);
        tick();
        chk("wd_resync_phase", 64'(b0.phase), 64'(PH_GREEN));
        chk("wd_resync_seq", 64'(b0.seq_err), 64'(!wd));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
